// File: rtl/cacode_nco_gen_if.sv
// Configuration, NCO rate, slew handshake and code outputs of cacode_nco_gen.
interface cacode_nco_gen_if #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned OMEGA_W = PHASE_W
);
  logic [9:0]         g1_init;
  logic [9:0]         g2_init;
  logic [3:0]         t0;
  logic [3:0]         t1;
  logic [OMEGA_W-1:0] nco_omega;
  logic               load;
  logic               slew_req;
  logic               slew_dir;
  logic [9:0]         slew_chips;
  logic               slew_ack;
  logic               slew_busy;
  logic               chip;
  logic               chip_strobe;
  logic               epoch;
  logic [9:0]         chip_idx;
  logic [PHASE_W-1:0] nco_phase;

  modport master (
    output g1_init, g2_init, t0, t1, nco_omega, load, slew_req, slew_dir, slew_chips,
    input  slew_ack, slew_busy, chip, chip_strobe, epoch, chip_idx, nco_phase
  );

  modport slave (
    input  g1_init, g2_init, t0, t1, nco_omega, load, slew_req, slew_dir, slew_chips,
    output slew_ack, slew_busy, chip, chip_strobe, epoch, chip_idx, nco_phase
  );
endinterface

// File: rtl/cacode_nco_gen.sv
// GPS L1 C/A code generator stepped by a phase-accumulator NCO.
// Define CACODE_NCO_SLEW_EN to include the advance/retard code-phase slew FSM.
module cacode_nco_gen #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned OMEGA_W = PHASE_W
) (
  input logic             clk,
  input logic             rst,
  cacode_nco_gen_if.slave bus
);
  localparam int unsigned SUM_W    = PHASE_W + 1;
  localparam logic [9:0]  LAST_IDX = 10'd1022;

  typedef struct packed {
    logic [9:0] g1;
    logic [9:0] g2;
    logic [9:0] idx;
  } code_t;

  // One code step; the last chip reloads both LFSRs so the period is 1023 for any init.
  function automatic code_t step_f(input code_t s, input logic [9:0] g1i, input logic [9:0] g2i);
    code_t r;
    if (s.idx == LAST_IDX) begin
      r.g1  = g1i;
      r.g2  = g2i;
      r.idx = '0;
    end else begin
      r.g1  = {s.g1[8:0], s.g1[2] ^ s.g1[9]};
      r.g2  = {s.g2[8:0], s.g2[1] ^ s.g2[2] ^ s.g2[5] ^ s.g2[7] ^ s.g2[8] ^ s.g2[9]};
      r.idx = s.idx + 10'd1;
    end
    return r;
  endfunction

  function automatic logic tap_f(input logic [9:0] g, input logic [3:0] t);
    logic [3:0] sel;
    sel = (t == 4'd0 || t > 4'd10) ? 4'd9 : t - 4'd1;
    return g[sel];
  endfunction

  logic [PHASE_W-1:0] phase_q, phase_d;
  code_t              code_q, code_d, s1, s2;
  logic               strobe_q, strobe_d;
  logic               epoch_q, epoch_d;
  logic               carry;
  logic [1:0]         n_steps;
  logic               adv_extra;
  logic               swallow;

  assign {carry, phase_d} = {1'b0, phase_q} + SUM_W'(bus.nco_omega);

  // Apply 0..2 sequential code steps; a wrap on either step raises epoch.
  always_comb begin
    s1       = step_f(code_q, bus.g1_init, bus.g2_init);
    s2       = step_f(s1, bus.g1_init, bus.g2_init);
    n_steps  = 2'(carry) + 2'(adv_extra) - 2'(swallow);
    code_d   = code_q;
    epoch_d  = 1'b0;
    strobe_d = (n_steps != 2'd0);
    case (n_steps)
      2'd1: begin
        code_d  = s1;
        epoch_d = (code_q.idx == LAST_IDX);
      end
      2'd2: begin
        code_d  = s2;
        epoch_d = (code_q.idx == LAST_IDX) || (s1.idx == LAST_IDX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || bus.load) begin
      phase_q    <= '0;
      code_q.g1  <= bus.g1_init;
      code_q.g2  <= bus.g2_init;
      code_q.idx <= '0;
      strobe_q   <= 1'b0;
      epoch_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      epoch_q  <= epoch_d;
    end
  end

`ifdef CACODE_NCO_SLEW_EN
  typedef enum logic [1:0] {S_IDLE, S_ADV, S_RET, S_ACK} slew_state_e;

  slew_state_e state_q, state_d;
  logic [9:0]  rem_q, rem_d;
  logic        armed_q, armed_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      armed_q <= armed_d;
    end
  end

  // armed_q blocks a request that stays high through ACK until it has been seen low.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    armed_d   = armed_q | ~bus.slew_req;
    adv_extra = 1'b0;
    swallow   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.slew_req && armed_q && !bus.load) begin
          armed_d = 1'b0;
          rem_d   = bus.slew_chips;
          if (bus.slew_chips == 10'd0) state_d = S_ACK;
          else if (bus.slew_dir)       state_d = S_ADV;
          else                         state_d = S_RET;
        end
      end
      S_ADV: begin
        adv_extra = 1'b1;
        rem_d     = rem_q - 10'd1;
        if (rem_q == 10'd1) state_d = S_ACK;
      end
      S_RET: begin
        if (carry) begin
          swallow = 1'b1;
          rem_d   = rem_q - 10'd1;
          if (rem_q == 10'd1) state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.load && (state_q == S_ADV || state_q == S_RET)) state_d = S_ACK;
  end

  assign bus.slew_ack  = (state_q == S_ACK);
  assign bus.slew_busy = (state_q == S_ADV) || (state_q == S_RET);
`else
  logic unused_slew;
  assign unused_slew   = ^{bus.slew_req, bus.slew_dir, bus.slew_chips};
  assign adv_extra     = 1'b0;
  assign swallow       = 1'b0;
  assign bus.slew_ack  = 1'b0;
  assign bus.slew_busy = 1'b0;
`endif

  assign bus.chip        = code_q.g1[9] ^ tap_f(code_q.g2, bus.t0) ^ tap_f(code_q.g2, bus.t1);
  assign bus.chip_strobe = strobe_q;
  assign bus.epoch       = epoch_q;
  assign bus.chip_idx    = code_q.idx;
  assign bus.nco_phase   = phase_q;
endmodule
